m_mem_access: RTL

Memory-stage load/store unit for the pipelined MIPS core. Directly downstream of the execute-stage ALU: it takes the ALU result as the effective address, performs byte/halfword/word loads and stores on a single-master data bus with a request/grant and read-valid handshake, and stalls the pipeline until the access completes. It performs little-endian lane steering, byte enables, load sign/zero extension and alignment checking.

---
 rtl/mem_pkg.sv | 68 ++++++
 rtl/m_load_ext.sv | 26 ++
 rtl/m_mem_access.sv | 128 ++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory-stage load/store unit.
// Op codes, FSM states, byte-enable/alignment/store-lane functions.
package mem_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned OPW  = 4;
  localparam int unsigned BEW  = 4;

  typedef enum logic [OPW-1:0] {
    MEM_NONE = 4'd0,
    MEM_LB   = 4'd1,
    MEM_LBU  = 4'd2,
    MEM_LH   = 4'd3,
    MEM_LHU  = 4'd4,
    MEM_LW   = 4'd5,
    MEM_SB   = 4'd6,
    MEM_SH   = 4'd7,
    MEM_SW   = 4'd8
  } memop_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic is_load(input logic [OPW-1:0] op);
    case (op)
      MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW: is_load = 1'b1;
      default:                                  is_load = 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input logic [OPW-1:0] op);
    case (op)
      MEM_SB, MEM_SH, MEM_SW: is_store = 1'b1;
      default:                is_store = 1'b0;
    endcase
  endfunction

  function automatic logic [BEW-1:0] be_of(input logic [OPW-1:0] op, input logic [1:0] addr);
    case (op)
      MEM_SB:  be_of = 4'b0001 << addr;
      MEM_SH:  be_of = addr[1] ? 4'b1100 : 4'b0011;
      MEM_SW:  be_of = 4'b1111;
      default: be_of = 4'b0000;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [OPW-1:0] op, input logic [1:0] addr);
    case (op)
      MEM_LH, MEM_LHU, MEM_SH: is_misaligned = addr[0];
      MEM_LW, MEM_SW:          is_misaligned = |addr;
      default:                 is_misaligned = 1'b0;
    endcase
  endfunction

  // Replicate the store operand across every lane it could land in.
  function automatic logic [XLEN-1:0] wdata_of(input logic [OPW-1:0] op, input logic [XLEN-1:0] data);
    case (op)
      MEM_SB:  wdata_of = {4{data[7:0]}};
      MEM_SH:  wdata_of = {2{data[15:0]}};
      default: wdata_of = data;
    endcase
  endfunction

endpackage

// File: rtl/m_load_ext.sv
// Load lane selection and sign/zero extension of the returned bus word.
module m_load_ext
  import mem_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [OPW-1:0]  op,
  input  logic [1:0]      addr_lo,
  output logic [XLEN-1:0] result
);

  logic [XLEN-1:0] lane;

  assign lane = rdata >> {addr_lo, 3'b000};

  always_comb begin
    result = lane;
    case (op)
      MEM_LB:  result = {{24{lane[7]}}, lane[7:0]};
      MEM_LBU: result = {24'd0, lane[7:0]};
      MEM_LH:  result = {{16{lane[15]}}, lane[15:0]};
      MEM_LHU: result = {16'd0, lane[15:0]};
      default: result = lane;
    endcase
  end

endmodule

// File: rtl/m_mem_access.sv
// Memory-stage load/store unit: request/grant bus FSM, lane steering,
// alignment exceptions and pipeline stall generation.
module m_mem_access
  import mem_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_con_Valid,
  input  logic [OPW-1:0]  i_con_MemOp,
  input  logic [XLEN-1:0] i_data_AluRes,
  input  logic [XLEN-1:0] i_data_Store,
  output logic            o_con_Stall,
  output logic            o_con_LoadValid,
  output logic [XLEN-1:0] o_data_Load,
  output logic            o_con_AdEL,
  output logic            o_con_AdES,
  output logic            o_bus_Req,
  output logic            o_bus_We,
  output logic [XLEN-1:0] o_bus_Addr,
  output logic [BEW-1:0]  o_bus_BE,
  output logic [XLEN-1:0] o_bus_WData,
  input  logic            i_bus_Gnt,
  input  logic            i_bus_RValid,
  input  logic [XLEN-1:0] i_bus_RData
);

  state_t          state_q, state_d;
  logic [OPW-1:0]  op_q;
  logic [1:0]      addr_lo_q;
  logic [XLEN-1:0] addr_q;
  logic [BEW-1:0]  be_q;
  logic [XLEN-1:0] wdata_q;
  logic            we_q;
  logic [XLEN-1:0] load_q;
  logic [XLEN-1:0] load_ext;

  logic mem_op, misaligned, accept;
  logic stall_c, req_c, load_valid_c, adel_c, ades_c;

  assign mem_op     = i_con_Valid && (is_load(i_con_MemOp) || is_store(i_con_MemOp));
  assign misaligned = is_misaligned(i_con_MemOp, i_data_AluRes[1:0]);
  assign accept     = (state_q == ST_IDLE) && mem_op && !misaligned;

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_REQ;
      ST_REQ:  if (i_bus_Gnt) state_d = is_store(op_q) ? ST_DONE : ST_WAIT;
      ST_WAIT: if (i_bus_RValid) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Stall and exceptions in IDLE are combinational so the E/M register holds at once.
  always_comb begin
    stall_c      = 1'b0;
    req_c        = 1'b0;
    load_valid_c = 1'b0;
    adel_c       = 1'b0;
    ades_c       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_op && !i_rst) begin
          if (misaligned) begin
            adel_c = is_load(i_con_MemOp);
            ades_c = is_store(i_con_MemOp);
          end else begin
            stall_c = 1'b1;
          end
        end
      end
      ST_REQ: begin
        req_c   = 1'b1;
        stall_c = 1'b1;
      end
      ST_WAIT: stall_c = 1'b1;
      ST_DONE: load_valid_c = is_load(op_q);
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      op_q      <= OPW'(0);
      addr_lo_q <= 2'd0;
      addr_q    <= XLEN'(0);
      be_q      <= BEW'(0);
      wdata_q   <= XLEN'(0);
      we_q      <= 1'b0;
      load_q    <= XLEN'(0);
    end else begin
      if (accept) begin
        op_q      <= i_con_MemOp;
        addr_lo_q <= i_data_AluRes[1:0];
        addr_q    <= {i_data_AluRes[XLEN-1:2], 2'b00};
        be_q      <= be_of(i_con_MemOp, i_data_AluRes[1:0]);
        wdata_q   <= wdata_of(i_con_MemOp, i_data_Store);
        we_q      <= is_store(i_con_MemOp);
      end
      if (state_q == ST_WAIT && i_bus_RValid) load_q <= load_ext;
    end
  end

  m_load_ext u_load_ext (
    .rdata   (i_bus_RData),
    .op      (op_q),
    .addr_lo (addr_lo_q),
    .result  (load_ext)
  );

  assign o_con_Stall     = stall_c;
  assign o_con_LoadValid = load_valid_c;
  assign o_con_AdEL      = adel_c;
  assign o_con_AdES      = ades_c;
  assign o_bus_Req       = req_c;
  assign o_bus_We        = we_q;
  assign o_bus_Addr      = addr_q;
  assign o_bus_BE        = be_q;
  assign o_bus_WData     = wdata_q;
  assign o_data_Load     = load_q;

endmodule
